// File: rtl/sprite_pkg.sv
// Shared sizes, key colour and FSM state type for the sprite blitter.
package sprite_pkg;
  localparam int SPRITE_DIM    = 16;
  localparam int SPRITE_PIXELS = 256;
  localparam int NUM_SPRITES   = 32;
  localparam int ROM_AW        = 13;
  localparam int RGB_W         = 24;

  localparam int DIM_W = $clog2(SPRITE_DIM);
  localparam int PIX_W = $clog2(SPRITE_PIXELS);
  localparam int ID_W  = $clog2(NUM_SPRITES);

  localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;
endpackage

// File: rtl/blit_pixel_pipe.sv
// Two-stage pixel pipe: stage 1 aligns the scan position with the ROM word,
// stage 2 applies key/clip tests and registers the framebuffer write.
module blit_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int               FB_W    = 160,
  parameter int               FB_H    = 120,
  parameter int               FB_AW   = 15,
  parameter logic [RGB_W-1:0] KEY_RGB = KEY_RGB_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_i,
  input  logic [DIM_W-1:0] px_i,
  input  logic [DIM_W-1:0] py_i,
  input  logic [7:0]       org_x_i,
  input  logic [6:0]       org_y_i,
  input  logic [RGB_W-1:0] rom_data_i,
  output logic             fb_wren_o,
  output logic [FB_AW-1:0] fb_addr_o,
  output logic [RGB_W-1:0] fb_data_o
);
  localparam logic [8:0] FB_W_L = 9'(FB_W);
  localparam logic [7:0] FB_H_L = 8'(FB_H);

  // Row-major framebuffer address; 17 bits covers 255*FB_W + 511.
  function automatic logic [FB_AW-1:0] fb_addr_f(input logic [8:0] dx, input logic [7:0] dy);
    logic [16:0] full;
    full = 17'(dy) * 17'(FB_W) + 17'(dx);
    return full[FB_AW-1:0];
  endfunction

  logic             vld_p1;
  logic [DIM_W-1:0] px_p1, py_p1;
  logic             wren_p2;
  logic [FB_AW-1:0] addr_p2;
  logic [RGB_W-1:0] data_p2;

  logic [8:0] dx;
  logic [7:0] dy;
  logic       hit;

  // Destination widened so a sprite hanging off the right/bottom edge never wraps.
  assign dx  = {1'b0, org_x_i} + 9'(px_p1);
  assign dy  = {1'b0, org_y_i} + 8'(py_p1);
  assign hit = vld_p1 && (rom_data_i != KEY_RGB) && (dx < FB_W_L) && (dy < FB_H_L);

  // ---- stage 1: scan position travels with the outstanding ROM read ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue_i;
    end
  end

  // Stage 1 data registers carry no reset; vld_p1 qualifies them.
  always_ff @(posedge clock) begin
    px_p1 <= px_i;
    py_p1 <= py_i;
  end

  // ---- stage 2: framebuffer write port; address/data hold when not writing ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wren_p2 <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
    end else begin
      wren_p2 <= hit;
      if (hit) begin
        addr_p2 <= fb_addr_f(dx, dy);
        data_p2 <= rom_data_i;
      end
    end
  end

  assign fb_wren_o = wren_p2;
  assign fb_addr_o = addr_p2;
  assign fb_data_o = data_p2;
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: command handshake, 16x16 scan FSM and ROM interface,
// feeding the key/clip pixel pipe that drives the framebuffer write port.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int               FB_W    = 160,
  parameter int               FB_H    = 120,
  parameter int               FB_AW   = 15,
  parameter logic [RGB_W-1:0] KEY_RGB = KEY_RGB_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_sprite_id,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  output logic              rom_rden,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_data,
  output logic              fb_wren,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [RGB_W-1:0]  fb_data,
  output logic              busy,
  output logic              done
);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(SPRITE_PIXELS - 1);
  localparam logic [PIX_W-1:0] DRAIN_LAST = PIX_W'(1);

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic              rden_q, busy_q, done_q;
  logic [ROM_AW-1:0] raddr_q;

  assign cmd_ready = (state_q == IDLE);

  // Next state: cnt is the pixel index {py,px} in FETCH and the drain tick in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = FETCH;
          cnt_d   = '0;
          id_d    = cmd_sprite_id;
          x_d     = cmd_x;
          y_d     = cmd_y;
        end
      end
      FETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PIX_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered ROM/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rden_q  <= 1'b0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rden_q  <= (state_d == FETCH);
      if (state_d == FETCH) raddr_q <= {id_d, cnt_d};
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
    end
  end

  assign rom_rden = rden_q;
  assign rom_addr = raddr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  blit_pixel_pipe #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .FB_AW  (FB_AW),
    .KEY_RGB(KEY_RGB)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .issue_i   (rden_q),
    .px_i      (cnt_q[DIM_W-1:0]),
    .py_i      (cnt_q[PIX_W-1:DIM_W]),
    .org_x_i   (x_q),
    .org_y_i   (y_q),
    .rom_data_i(rom_data),
    .fb_wren_o (fb_wren),
    .fb_addr_o (fb_addr),
    .fb_data_o (fb_data)
  );
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: ROM model, per-cycle behavioural model with
// compare on the falling edge, and directed draw commands with literal pins.
module tb_sprite_blitter;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_sprite_id = '0;
  logic [7:0]  cmd_x = '0;
  logic [6:0]  cmd_y = '0;
  logic        rom_rden;
  logic [12:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        fb_wren;
  logic [14:0] fb_addr;
  logic [23:0] fb_data;
  logic        busy, done;

  int total = 0, bad = 0;
  int cyc = 0;
  int mode = 0;

  sprite_blitter dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sprite_id(cmd_sprite_id), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rom_rden(rom_rden), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Sprite contents: never the key in mode 0; key at every even px in mode 1.
  function automatic logic [23:0] rom_fn(input int m, input int a);
    logic [23:0] w;
    w = 24'(a) ^ 24'h123456;
    if (m == 1 && (a % 2) == 0) w = KEY;
    return w;
  endfunction

  always @(posedge clock) if (rom_rden) rom_data <= rom_fn(mode, int'(rom_addr));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state and per-command statistics.
  bit active = 0;
  int start = 0, cid = 0, cx = 0, cy = 0, acc_rel = -1;
  int h_raddr = 0, h_faddr = 0, h_fdata = 0;
  int n_wr, first_wa, first_wt, last_wa, done_t, n_done, n_busy, n_even, n_clip;
  int n_rd, first_ra, last_ra;

  task clear_stats();
    n_wr = 0; first_wa = -1; first_wt = -1; last_wa = -1; done_t = -1;
    n_done = 0; n_busy = 0; n_even = 0; n_clip = 0;
    n_rd = 0; first_ra = -1; last_ra = -1;
  endtask

  always @(negedge clock) begin : cmp
    int t, p, dx, dy, adx, ady;
    logic [23:0] pix;
    bit e_rd, e_busy, e_done, e_wr;
    if (reset) begin
      chk("rst_rom_rden", rom_rden, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_fb_wren", fb_wren, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      active = 0; h_raddr = 0; h_faddr = 0; h_fdata = 0;
      clear_stats();
    end else begin
      t      = active ? (cyc - start) : -1000;
      e_rd   = (t >= 0 && t <= 255);
      e_busy = (t >= 0 && t <= 257);
      e_done = (t == 258);
      if (e_rd) h_raddr = cid * 256 + t;
      e_wr = 0;
      if (t >= 2 && t <= 257) begin
        p   = t - 2;
        pix = rom_fn(mode, cid * 256 + p);
        dx  = cx + p % 16;
        dy  = cy + p / 16;
        if (pix != KEY && dx < 160 && dy < 120) begin
          e_wr    = 1;
          h_faddr = dy * 160 + dx;
          h_fdata = int'(pix);
        end
      end
      chk("rom_rden", rom_rden, e_rd);
      chk("rom_addr", rom_addr, h_raddr);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("fb_wren", fb_wren, e_wr);
      chk("fb_addr", fb_addr, h_faddr);
      chk("fb_data", fb_data, h_fdata);

      if (fb_wren) begin
        n_wr++;
        if (first_wa < 0) begin first_wa = fb_addr; first_wt = t; end
        last_wa = fb_addr;
        adx = fb_addr % 160;
        ady = fb_addr / 160;
        if (adx % 2 == 0) n_even++;
        if (adx < cx || ady < cy || ady >= 120) n_clip++;
      end
      if (rom_rden) begin
        if (n_rd == 0) first_ra = rom_addr;
        last_ra = rom_addr;
        n_rd++;
      end
      if (busy) n_busy++;
      if (done) begin n_done++; done_t = t; end

      if (cmd_valid && cmd_ready) begin
        acc_rel = active ? t : -1;
        active  = 1;
        start   = cyc + 1;
        cid     = cmd_sprite_id;
        cx      = cmd_x;
        cy      = cmd_y;
        clear_stats();
      end
    end
  end

  task automatic wait_ready();
    bit got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      if (cmd_ready) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_wait: cmd_ready never seen, required within 600 cycles");
    end
  endtask

  task automatic issue(input int id, input int x, input int y);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_sprite_id = 5'(id);
    cmd_x = 8'(x);
    cmd_y = 7'(y);
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // Basic draw
    mode = 0;
    issue(3, 10, 20);
    repeat (262) @(posedge clock);
    chk("basic_writes", n_wr, 256);
    chk("basic_first_addr", first_wa, 3210);
    chk("basic_first_cycle", first_wt, 2);
    chk("basic_last_addr", last_wa, 5625);
    chk("basic_done_cycle", done_t, 258);
    chk("basic_done_count", n_done, 1);
    chk("basic_rom_first", first_ra, 768);
    chk("basic_rom_last", last_ra, 1023);
    chk("basic_busy_cycles", n_busy, 258);

    // Transparency
    mode = 1;
    issue(3, 10, 20);
    repeat (262) @(posedge clock);
    chk("key_writes", n_wr, 128);
    chk("key_even_dx_writes", n_even, 0);

    // Clipping
    mode = 0;
    issue(0, 150, 110);
    repeat (262) @(posedge clock);
    chk("clip_writes", n_wr, 100);
    chk("clip_out_of_range", n_clip, 0);
    chk("clip_done_cycle", done_t, 258);

    // Fully off-screen
    issue(0, 255, 127);
    repeat (262) @(posedge clock);
    chk("off_writes", n_wr, 0);
    chk("off_busy_cycles", n_busy, 258);
    chk("off_done_count", n_done, 1);

    // Held cmd_valid with inputs changed mid-draw
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_sprite_id = 5'd1; cmd_x = 8'd20; cmd_y = 7'd30;
    wait_ready();
    @(posedge clock); #1;
    cmd_sprite_id = 5'd2; cmd_x = 8'd40; cmd_y = 7'd5;
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("b2b_accept_cycle", acc_rel, 258);
    repeat (262) @(posedge clock);
    chk("b2b_writes", n_wr, 256);
    chk("b2b_first_addr", first_wa, 840);
    chk("b2b_first_cycle", first_wt, 2);
    chk("b2b_rom_first", first_ra, 512);

    // Reset mid-draw
    issue(5, 0, 0);
    repeat (100) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_fb_wren", fb_wren, 0);
    chk("midrst_rom_rden", rom_rden, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (300) @(posedge clock);
    chk("postrst_writes", n_wr, 0);
    chk("postrst_done", n_done, 0);
    chk("postrst_busy", n_busy, 0);

    // Recovery after reset
    issue(3, 10, 20);
    repeat (262) @(posedge clock);
    chk("recover_writes", n_wr, 256);
    chk("recover_done_cycle", done_t, 258);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
